// File: rtl/div_issue_stage_pkg.sv
// Shared types for the divide issue stage:
// FSM encoding, CPSR flag positions, counter sizing.
package div_issue_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // CPSR packing {negative, zero, cout, overflow, invalid}
  localparam int FL_N = 4;
  localparam int FL_Z = 3;
  localparam int FL_C = 2;
  localparam int FL_V = 1;
  localparam int FL_I = 0;
  localparam int FL_W = 5;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_issue_stage_if.sv
// Operand/result handshake bundle for the
// divide issue stage.
interface div_issue_stage_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             negative;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             invalid;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid,
    input  quo, rem,
    input  negative, zero, cout,
    input  overflow, invalid
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid,
    output quo, rem,
    output negative, zero, cout,
    output overflow, invalid
  );

endinterface

// File: rtl/div_core.sv
// Combinational signed divider: unsigned
// restoring array plus quotient sign fixup.
module div_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem_mag
);

  logic [WIDTH-1:0] w_ax;
  logic [WIDTH-1:0] w_ay;
  logic [WIDTH:0]   w_r;
  logic [WIDTH-1:0] w_q;
  logic             w_qneg;

  // -MIN wraps to MIN, which is still the
  // right magnitude when read as unsigned
  assign w_ax = i_x[WIDTH-1] ? -i_x : i_x;
  assign w_ay = i_y[WIDTH-1] ? -i_y : i_y;

  always_comb begin
    w_r = '0;
    w_q = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_r = {w_r[WIDTH-1:0], w_ax[i]};
      if (w_r >= {1'b0, w_ay}) begin
        w_r    = w_r - {1'b0, w_ay};
        w_q[i] = 1'b1;
      end
    end
  end

  assign w_qneg    = i_x[WIDTH-1] ^ i_y[WIDTH-1];
  assign o_quo     = w_qneg ? -w_q : w_q;
  assign o_rem_mag = w_r[WIDTH-1:0];

endmodule

// File: rtl/div_issue_stage.sv
// Multicycle wrapper around div_core: accept,
// settle, then register corrected results.
module div_issue_stage
  import div_issue_stage_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  div_issue_stage_if.slave bus
);

  localparam int CW = cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_rem;
  logic [FL_W-1:0]   r_flags;
  logic              w_ld_op;
  logic              w_ld_res;
  logic              w_in_ready;
  logic [WIDTH-1:0]  w_core_quo;
  logic [WIDTH-1:0]  w_core_rem;
  logic [WIDTH-1:0]  w_quo;
  logic [WIDTH-1:0]  w_rem;
  logic [FL_W-1:0]   w_flags;

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_x       (r_x),
    .i_y       (r_y),
    .o_quo     (w_core_quo),
    .o_rem_mag (w_core_rem)
  );

  always_comb begin
    w_quo   = w_core_quo;
    w_rem   = w_core_rem;
    w_flags = '0;
    unique case (1'b1)
      (r_y == '0): begin
        w_quo         = '1;
        w_rem         = r_x;
        w_flags[FL_I] = 1'b1;
      end
      (r_x == MIN_NEG && r_y == '1): begin
        w_quo         = r_x;
        w_rem         = '0;
        w_flags[FL_V] = 1'b1;
      end
      default: begin
        if (r_x[WIDTH-1] && w_core_rem != '0)
          w_rem = -w_core_rem;
      end
    endcase
    // flags follow the corrected quotient
    w_flags[FL_N] = w_quo[WIDTH-1];
    w_flags[FL_Z] = (w_quo == '0);
    w_flags[FL_C] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld_op     = 1'b0;
    w_ld_res    = 1'b0;
    w_in_ready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ld_op     = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_ld_res    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_ld_op     = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ld_op) begin
        r_x <= bus.x;
        r_y <= bus.y;
      end
      if (w_ld_res) begin
        r_quo   <= w_quo;
        r_rem   <= w_rem;
        r_flags <= w_flags;
      end
    end
  end

  // ready is forced low while reset is held
  assign bus.in_ready  = w_in_ready & rst_n;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.quo       = r_quo;
  assign bus.rem       = r_rem;
  assign bus.negative  = r_flags[FL_N];
  assign bus.zero      = r_flags[FL_Z];
  assign bus.cout      = r_flags[FL_C];
  assign bus.overflow  = r_flags[FL_V];
  assign bus.invalid   = r_flags[FL_I];

endmodule

// File: tb/tb_div_issue_stage.sv
// Scoreboard bench for div_issue_stage with an
// integer-arithmetic reference model.
module tb_div_issue_stage;

  localparam int W  = 16;
  localparam int SC = 4;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic [4:0]   fl;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   bp_hold = 1'b0;
  bit   force_rdy = 1'b0;
  bit   rnd_rdy = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  div_issue_stage_if #(.WIDTH(W)) bus();

  div_issue_stage #(
    .WIDTH         (W),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_rdy <= ($urandom_range(0, 3) != 0);
  end

  assign bus.out_ready = !bp_hold && (force_rdy || rnd_rdy);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input int acc);
    exp_t e;
    int xi, yi, q, r;
    xi = int'($signed(x));
    yi = int'($signed(y));
    e.acc = acc;
    e.fl = '0;
    if (yi == 0) begin
      e.quo = '1;
      e.rem = x;
      e.fl[0] = 1'b1;
    end else begin
      q = xi / yi;
      r = xi % yi;
      e.quo = q[W-1:0];
      e.rem = r[W-1:0];
      if (xi == -(2 ** (W - 1)) && yi == -1) e.fl[1] = 1'b1;
    end
    e.fl[4] = e.quo[W-1];
    e.fl[3] = (e.quo == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       output int waits);
    waits = 0;
    bus.x = x;
    bus.y = y;
    bus.in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) break;
    end
    if (waits > 200) begin
      n_tot++;
      $display("FAIL accept: in_ready never high for %0h/%0h", x, y);
    end else begin
      sb.push_back(model(x, y, cyc + 1));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    force_rdy = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    force_rdy = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL spurious out_valid at cycle %0d", cyc);
        end else begin
          chk("latency", cyc - sb[0].acc, SC);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL result with empty scoreboard: quo %0h", bus.quo);
        end else begin
          mon_e = sb.pop_front();
          chk("quo", {16'h0, bus.quo}, {16'h0, mon_e.quo});
          chk("rem", {16'h0, bus.rem}, {16'h0, mon_e.rem});
          chk("flags",
              {27'h0, bus.negative, bus.zero, bus.cout,
               bus.overflow, bus.invalid},
              {27'h0, mon_e.fl});
        end
      end
    end
    prev_v <= bus.out_valid && rst_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] dx [6];
    logic [W-1:0] dy [6];
    logic [W-1:0] rx, ry;
    exp_t bp;
    int w, n;

    dx = '{16'd100, 16'hFF9C, 16'd100, 16'd5, 16'h8000, 16'd3};
    dy = '{16'd7, 16'd7, 16'hFFF9, 16'd0, 16'hFFFF, 16'd7};
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_quo", bus.quo, 0);
    chk("rst_rem", bus.rem, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) issue(dx[i], dy[i], w);

    for (int i = 0; i < 60; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      n = $urandom_range(0, 9);
      if (n == 0) ry = '0;
      if (n == 1) ry = '1;
      if (n == 2) ry = W'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) rx = 16'h8000;
      if ($urandom_range(0, 7) == 0) rx = W'($urandom_range(0, 20));
      issue(rx, ry, w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    bp_hold = 1'b1;
    issue(16'd1000, 16'hFFFD, w);
    bp = model(16'd1000, 16'hFFFD, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_quo_stable", bus.quo, bp.quo);
      chk("bp_rem_stable", bus.rem, bp.rem);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bp_hold = 1'b0;
    force_rdy = 1'b1;
    issue(16'd77, 16'd5, w);
    chk("bp_same_edge_accept", w, 0);
    drain();

    issue(16'd50, 16'd7, w);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_quo", bus.quo, 0);
    chk("abort_rem", bus.rem, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_abort_valid", bus.out_valid, 0);
      chk("post_abort_quo", bus.quo, 0);
    end
    @(posedge clk);
    #1;
    issue(16'd9, 16'd3, w);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
